mac_shift_add_unit: RTL and testbench

//  Iterative shift-add multiply-accumulate stage. Sits directly downstream of the two
//  8-bit operand registers and consumes their Q outputs as A and B.

---
 rtl/mac_shift_add_unit.sv | 169 ++++++++++++++++
 tb/tb_mac_shift_add_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mac_shift_add_unit.sv
// ============================================================================
// Module      : mac_shift_add_unit
// Description : Iterative shift-add multiply-accumulate with valid/ready intake,
//               sticky overflow and a DONE pulse per accumulate.
//               Optional macro MAC_SATURATE_EN clamps ACC on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_shift_add_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 CLK,
  input  logic                 RST_bar,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 CLR,
  output logic [ACC_WIDTH-1:0] ACC,
  output logic                 OVF,
  output logic                 DONE
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PROD_W-1:0]     r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [PROD_W-1:0]     r_prod;
  logic [CNT_W-1:0]      r_cnt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_ovf;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_in_accum;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_carry;
  logic [ACC_WIDTH-1:0]  w_acc_on_carry;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_in_accum  = 1'b0;
    case (r_state)
      S_IDLE: begin
        IN_READY = RST_bar;
        w_accept = IN_VALID & RST_bar;
        if (w_accept) begin
          w_state_nxt = S_MULT;
        end
      end
      S_MULT: begin
        // Fixed WIDTH iterations regardless of operand values.
        w_last = (r_cnt == c_cnt_last);
        if (w_last) begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_in_accum  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiplier datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= PROD_W'(A);
      r_mplier <= B;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MULT) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  assign w_sum   = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_prod);
  assign w_carry = w_sum[ACC_WIDTH];

`ifdef MAC_SATURATE_EN
  assign w_acc_on_carry = {ACC_WIDTH{1'b1}};
`else
  assign w_acc_on_carry = w_sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_accum) begin
      // Clear on the accumulate edge means clear-then-add.
      if (CLR) begin
        r_acc <= ACC_WIDTH'(r_prod);
        r_ovf <= 1'b0;
      end else if (w_carry) begin
        r_acc <= w_acc_on_carry;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end else if (CLR) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_in_accum;
    end
  end

  assign ACC  = r_acc;
  assign OVF  = r_ovf;
  assign DONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mac_shift_add_unit.sv
// ============================================================================
// Module      : tb_mac_shift_add_unit
// Description : Randomized and directed bench for mac_shift_add_unit against a
//               cycle-count reference model of the multiply-accumulate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_shift_add_unit;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 20;
  localparam longint c_acc_mod = longint'(1) << ACC_WIDTH;

  logic                 CLK;
  logic                 RST_bar;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic                 CLR;
  logic [ACC_WIDTH-1:0] ACC;
  logic                 OVF;
  logic                 DONE;

  int n_checks;
  int n_fail;

  // Reference model state: cycles remaining until the accumulate edge completes.
  int     m_busy;
  longint m_prod;
  longint m_acc;
  bit     m_ovf;
  bit     m_done;

  mac_shift_add_unit #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_dut (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .A       (A),
    .B       (B),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .CLR     (CLR),
    .ACC     (ACC),
    .OVF     (OVF),
    .DONE    (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check ready, clock, advance model, check outputs.
  task automatic step(input bit rst_n, input bit vld, input int a, input int b, input bit clr);
    longint sum;
    @(negedge CLK);
    RST_bar  = rst_n;
    IN_VALID = vld;
    A        = WIDTH'(a);
    B        = WIDTH'(b);
    CLR      = clr;
    #1;
    check_val("in_ready", longint'(IN_READY), longint'(m_busy == 0 && rst_n));
    @(posedge CLK);
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_ovf = 0; m_done = 0; m_prod = 0;
    end else begin
      m_done = (m_busy == 1);
      if (m_busy == 1) begin
        sum = m_acc + m_prod;
        if (clr) begin
          m_acc = m_prod; m_ovf = 0;
        end else if (sum >= c_acc_mod) begin
          m_ovf = 1;
`ifdef MAC_SATURATE_EN
          m_acc = c_acc_mod - 1;
`else
          m_acc = sum % c_acc_mod;
`endif
        end else begin
          m_acc = sum;
        end
      end else if (clr) begin
        m_acc = 0; m_ovf = 0;
      end
      if (m_busy > 0) begin
        m_busy--;
      end else if (vld) begin
        m_busy = WIDTH + 1;
        m_prod = longint'(a) * longint'(b);
      end
    end
    #1;
    check_val("acc", longint'(ACC), m_acc);
    check_val("ovf", longint'(OVF), longint'(m_ovf));
    check_val("done", longint'(DONE), longint'(m_done));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_busy = 0; m_prod = 0; m_acc = 0; m_ovf = 0; m_done = 0;
    RST_bar = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; CLR = 1'b0;

    // Reset and a single 3*5 operation
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 3, 5, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0);
      check_val("done_early", longint'(DONE), 0);
    end
    step(1, 0, 0, 0, 0);
    check_val("acc_3x5", longint'(ACC), 15);
    check_val("done_3x5", longint'(DONE), 1);
    step(1, 0, 0, 0, 0);
    check_val("done_pulse", longint'(DONE), 0);

    // Ten back-to-back 255*255 pairs with IN_VALID held
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10 * (WIDTH + 2); i++) step(1, 1, 255, 255, 0);
    while (m_busy != 0) step(1, 0, 0, 0, 0);
    check_val("acc_10x", longint'(ACC), 650250);
    check_val("ovf_10x", longint'(OVF), 0);

    // Seven more force a carry out of the accumulator
    for (int i = 0; i < 7 * (WIDTH + 2); i++) step(1, 1, 255, 255, 0);
    while (m_busy != 0) step(1, 0, 0, 0, 0);
`ifdef MAC_SATURATE_EN
    check_val("acc_ovf", longint'(ACC), 1048575);
`else
    check_val("acc_ovf", longint'(ACC), 56849);
`endif
    check_val("ovf_sticky", longint'(OVF), 1);

    // CLR exactly on the accumulate edge: clear-then-add
    step(1, 1, 4, 4, 0);
    while (m_busy != 1) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    check_val("clr_accum_acc", longint'(ACC), 16);
    check_val("clr_accum_ovf", longint'(OVF), 0);
    check_val("clr_accum_done", longint'(DONE), 1);

    // Reset on the 4th MULT cycle discards the product
    step(1, 1, 7, 9, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("rst_mid_acc", longint'(ACC), 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);

    // Zero multiplier still takes full latency; operands ignored while busy
    step(1, 1, 2, 0, 0);
    for (int i = 0; i < WIDTH + 4; i++) step(1, 1, $urandom_range(1, 255), $urandom_range(1, 255), 0);
    step(1, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 255),
           $urandom_range(0, 255),
           ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
